// File: rtl/delay_pipe_sched.sv
// Round-robin scheduler for two requesters sharing one fixed-latency delay pipe,
// with downstream credit tracking, a shadow owner-tag pipe, and a flush/drain FSM.
module delay_pipe_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 2,
    parameter int CREDITS    = 4
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] pipe_in_data,
    output logic                  pipe_in_vld,
    input  logic                  cred_ret,
    output logic                  out_vld,
    output logic                  out_id,
    output logic                  busy,
    output logic                  flush_done,
    output logic                  cred_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CW-1:0]      r_credits;
    logic               r_last_grant;
    logic               r_cred_err;
    logic [LATENCY-1:0] r_vld_p;
    logic [LATENCY-1:0] r_id_p;

    logic w_can_issue;
    logic w_grant1;
    logic w_issue;
    logic w_inflight;

    // Issue stays closed the same cycle flush rises or enable drops, before the FSM reacts.
    assign w_can_issue = (r_state == S_RUN) && (r_credits != '0) && enable && !flush;

    always_comb begin
        w_grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant1 = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant1 = 1'b1;
        end
    end

    assign req0_ready   = w_can_issue && req0_valid && !w_grant1;
    assign req1_ready   = w_can_issue && w_grant1;
    assign w_issue      = req0_ready || req1_ready;
    assign pipe_in_vld  = w_issue;
    assign pipe_in_data = req1_ready ? req1_data :
                          req0_ready ? req0_data : '0;

    assign w_inflight = |r_vld_p;
    assign out_vld    = r_vld_p[LATENCY-1];
    assign out_id     = r_id_p[LATENCY-1];
    assign busy       = (r_state != S_IDLE) || w_inflight;
    assign flush_done = (r_state == S_FLUSH) && !w_inflight;
    assign cred_err   = r_cred_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (enable && !flush) w_state_nxt = S_RUN;
            S_RUN:   if (flush || !enable) w_state_nxt = S_FLUSH;
            S_FLUSH: if (!w_inflight) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control stage: FSM, round-robin pointer, credits
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_credits    <= CRED_MAX;
            r_cred_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_last_grant <= req1_ready;
            end
            if (w_issue && !cred_ret) begin
                r_credits <= r_credits - CW'(1);
            end else if (!w_issue && cred_ret && (r_credits != CRED_MAX)) begin
                r_credits <= r_credits + CW'(1);
            end
            if (cred_ret && (r_credits == CRED_MAX)) begin
                r_cred_err <= 1'b1;
            end
        end
    end

    // Shadow stages _p0.._p(LATENCY-1): owner tag travels beside the external pipe data
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_vld_p <= '0;
            r_id_p  <= '0;
        end else begin
            r_vld_p[0] <= w_issue;
            r_id_p[0]  <= req1_ready;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
                r_id_p[i]  <= r_id_p[i-1];
            end
        end
    end

endmodule

// File: tb/tb_delay_pipe_sched.sv
// Bench for delay_pipe_sched: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a queue-based reference model.
module tb_delay_pipe_sched;

    localparam int DW  = 8;
    localparam int LAT = 2;
    localparam int CRD = 4;

    logic          clk = 1'b0;
    logic          aclr;
    logic          enable, flush, cred_ret;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready, pipe_in_vld;
    logic [DW-1:0] pipe_in_data;
    logic          out_vld, out_id, busy, flush_done, cred_err;

    int n_checks = 0;
    int n_errors = 0;

    delay_pipe_sched #(.DATA_WIDTH(DW), .LATENCY(LAT), .CREDITS(CRD)) dut (
        .clk(clk), .aclr(aclr), .enable(enable), .flush(flush),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .pipe_in_data(pipe_in_data), .pipe_in_vld(pipe_in_vld),
        .cred_ret(cred_ret), .out_vld(out_vld), .out_id(out_id),
        .busy(busy), .flush_done(flush_done), .cred_err(cred_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: state 0=idle 1=run 2=flush; results kept as a queue of due cycles.
    int      m_state = 0;
    int      m_cred  = CRD;
    bit      m_last  = 1'b1;
    bit      m_err   = 1'b0;
    int      m_cyc   = 0;
    int      due_q[$];
    bit      id_q[$];

    bit      e_r0, e_r1, e_vld, e_ovld, e_oid, e_busy, e_fd, e_infl;
    logic [DW-1:0] e_data;

    function void m_eval();
        bit can, g1;
        can = (m_state == 1) && (m_cred > 0) && enable && !flush;
        if (req0_valid && req1_valid) g1 = (m_last == 1'b0);
        else                          g1 = req1_valid;
        e_r1   = can && req1_valid && g1;
        e_r0   = can && req0_valid && !g1;
        e_vld  = e_r0 || e_r1;
        e_data = e_r1 ? req1_data : (e_r0 ? req0_data : '0);
        e_infl = (due_q.size() > 0);
        e_ovld = e_infl && (due_q[0] == m_cyc);
        e_oid  = e_ovld ? id_q[0] : 1'b0;
        e_busy = (m_state != 0) || e_infl;
        e_fd   = (m_state == 2) && !e_infl;
    endfunction

    always @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            m_state = 0;
            m_cred  = CRD;
            m_last  = 1'b1;
            m_err   = 1'b0;
            due_q.delete();
            id_q.delete();
        end else begin
            m_eval();
            if (e_vld) begin
                due_q.push_back(m_cyc + LAT);
                id_q.push_back(e_r1);
                m_last = e_r1;
            end
            if (cred_ret && m_cred == CRD) m_err = 1'b1;
            if (e_vld && !cred_ret)                    m_cred--;
            else if (!e_vld && cred_ret && m_cred < CRD) m_cred++;
            case (m_state)
                0: if (enable && !flush) m_state = 1;
                1: if (flush || !enable) m_state = 2;
                2: if (!e_infl) m_state = 0;
                default: m_state = 0;
            endcase
            m_cyc++;
            while (due_q.size() > 0 && due_q[0] < m_cyc) begin
                void'(due_q.pop_front());
                void'(id_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        m_eval();
        chk("req0_ready",   req0_ready,   e_r0);
        chk("req1_ready",   req1_ready,   e_r1);
        chk("pipe_in_vld",  pipe_in_vld,  e_vld);
        chk("pipe_in_data", pipe_in_data, e_data);
        chk("out_vld",      out_vld,      e_ovld);
        chk("out_id",       out_id,       e_oid);
        chk("busy",         busy,         e_busy);
        chk("flush_done",   flush_done,   e_fd);
        chk("cred_err",     cred_err,     m_err);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, fd;
        int g[4];
        aclr = 1'b0; enable = 1'b0; flush = 1'b0; cred_ret = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
        #2;
        chk("rst_out_vld",  out_vld, 0);
        chk("rst_ready0",   req0_ready, 0);
        chk("rst_pipe_vld", pipe_in_vld, 0);
        chk("rst_busy",     busy, 0);
        chk("rst_cred_err", cred_err, 0);
        step(); aclr = 1'b1;

        // Single requester: first ready one cycle after enable, then credits run out at 4
        step(); enable = 1'b1; req0_valid = 1'b1; req0_data = 8'h11;
        #2 chk("idle_no_ready", req0_ready, 0);
        step(); #2;
        chk("first_ready", req0_ready, 1);
        chk("first_data",  pipe_in_data, 8'h11);
        n = 1;
        for (int i = 0; i < 8; i++) begin
            step(); #2;
            n += int'(req0_ready);
            if (i == 1) begin
                chk("lat2_out_vld", out_vld, 1);
                chk("lat2_out_id",  out_id, 0);
            end
        end
        chk("issues_4_credits", n, 4);

        step(); cred_ret = 1'b1;
        #2 chk("no_credit_ready", req0_ready, 0);
        step(); cred_ret = 1'b0;
        #2 chk("one_more_issue", req0_ready, 1);
        step(); #2 chk("back_to_zero", req0_ready, 0);

        // Return lands while credits are 0, then issue + return together holds credits at 1
        step(); cred_ret = 1'b1;
        step();
        step(); cred_ret = 1'b0;
        #2 chk("cred1_issue", req0_ready, 1);
        step(); #2 chk("cred1_spent", req0_ready, 0);

        // Overfill credits: 4 returns refill, the 5th flags cred_err
        step(); req0_valid = 1'b0; cred_ret = 1'b1;
        repeat (4) step();
        step(); cred_ret = 1'b0;
        #2 chk("cred_err_set", cred_err, 1);
        step(); req0_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #2 n += int'(req0_ready);
            step();
        end
        chk("credits_stay_4", n, 4);

        // Reset clears the sticky error; then round robin with both requesters
        req0_valid = 1'b0;
        step(); aclr = 1'b0;
        #2 chk("err_cleared", cred_err, 0);
        step(); aclr = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 8'hA0; req1_data = 8'hB1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 1) cred_ret = 1'b1;
            #2 g[i] = req1_ready ? 1 : (req0_ready ? 0 : 2);
        end
        chk("rr_grant0", g[0], 0);
        chk("rr_grant1", g[1], 1);
        chk("rr_grant2", g[2], 0);
        chk("rr_grant3", g[3], 1);

        // Flush: readys drop at once, in-flight results drain, flush_done pulses
        step(); flush = 1'b1; cred_ret = 1'b0;
        #2;
        chk("flush_ready_drop", req0_ready | req1_ready, 0);
        n = int'(out_vld); fd = int'(flush_done);
        for (int i = 0; i < 6; i++) begin
            step(); #2;
            n += int'(out_vld);
            fd += int'(flush_done);
        end
        chk("flush_drain_cnt", n, 2);
        chk("flush_done_once", fd, 1);
        chk("flush_idle_busy", busy, 0);

        // Asynchronous reset while streaming
        step(); flush = 1'b0; cred_ret = 1'b1;
        repeat (4) step();
        #1 chk("stream_busy", busy, 1);
        aclr = 1'b0;
        #1;
        chk("async_out_vld", out_vld, 0);
        chk("async_ready",   req0_ready | req1_ready, 0);
        chk("async_busy",    busy, 0);
        step(); aclr = 1'b1; cred_ret = 1'b0;
        step(); #2 chk("post_rst_tie_req0", req0_ready, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            enable     = ($urandom_range(15) != 0);
            flush      = ($urandom_range(31) == 0);
            req0_valid = $urandom_range(1);
            req1_valid = $urandom_range(1);
            req0_data  = DW'($urandom);
            req1_data  = DW'($urandom);
            cred_ret   = ($urandom_range(2) == 0);
            aclr       = ($urandom_range(499) != 0);
        end
        step(); aclr = 1'b1;
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
